fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Owns the program counter in the IF stage and issues sequential instruction-memory requests.
- Consumes the branch/jump redirect produced in ID: a flag plus a 32-bit target, valid while the branch sits in ID.
- Consumes exception flushes from the pipeline.
- Honours the MIPS single delay slot: the instruction after a branch is always fetched before the target.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- ADDR_WIDTH, 32, width of PC and all address ports.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_if  input  1  downstream stage cannot accept a new fetched PC.
- flush  input  1  exception/eret redirect; highest priority.
- flush_pc  input  ADDR_WIDTH  redirect target when flush=1.
- branch_flag  input  1  ID redirect request (level; may repeat while ID stalls).
- branch_addr  input  ADDR_WIDTH  ID redirect target.
- rom_en  output  1  instruction-memory request.
- rom_addr  output  ADDR_WIDTH  request address, always equal to pc.
- rom_ready  input  1  request completes at the edge where rom_en && rom_ready.
- pc_out  output  ADDR_WIDTH  PC of the last completed fetch, to IF/ID.
- pc_valid  output  1  pc_out holds a valid fetched instruction.
- redirect_pending  output  1  a branch target is latched, not yet applied.

Behaviour:
- Reset (async, any state): pc=RESET_PC; state=IDLE; rom_en=0; pc_out=0; pc_valid=0; pending=0; pend_addr=0.
- States:
  - IDLE: rom_en=0; unconditionally goes to FETCH next cycle.
  - FETCH: rom_en=1, rom_addr=pc.
  - HOLD: rom_en=0; completed fetch held.
- "Advance" is the event where pc moves to the next address:
  - FETCH with rom_ready=1 and stall_if=0: pc_out<=pc, pc_valid<=1, pc<=next, stay in FETCH.
  - FETCH with rom_ready=1 and stall_if=1: pc_out<=pc, pc_valid<=1, go to HOLD; pc unchanged.
  - HOLD with stall_if=0: pc<=next, go to FETCH. pc_out is unchanged; pc_valid<=0 unless the same edge completes a fetch.
- FETCH with rom_ready=0: pc_valid<=0 when stall_if=0; pc_valid is held when stall_if=1.
- next-PC priority:
  1. branch_flag=1 that cycle: branch_addr.
  2. pending=1: pend_addr.
  3. Otherwise: pc+4, modulo 2^32 (0xFFFFFFFC+4 = 0).
- On any advance, pending<=0.
- Redirect latching: when branch_flag=1 and no advance occurs that cycle, pending<=1 and pend_addr<=branch_addr. A repeated flag overwrites with the newest value.
- Delay slot: when branch_flag rises, pc already equals branch_pc+4. That fetch completes before the redirect takes effect, so the delay slot is never skipped.
- Flush (any state except during reset): on the edge, pc<=flush_pc, pending<=0, pc_valid<=0, state<=FETCH. Flush overrides a simultaneous branch_flag, rom_ready, or stall_if. A memory response completing in the flush cycle is discarded.
- redirect_pending equals the pending register.
- Latency: target address appears on rom_addr the cycle after the advancing edge.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro defined, an extra output adel_flag (1 bit) is present:
  - A redirect target (branch, pending, or flush) with addr[1:0]!=0 is still loaded into pc.
  - rom_en stays 0 for that pc.
  - At the next non-stalled edge: pc_out<=pc, pc_valid<=1, adel_flag<=1.
  - adel_flag clears on the next advance or on flush; its reset value is 0.
  - The pipeline raises AdEL from adel_flag.
- Without the macro: no adel_flag port, no check; bits [1:0] of the target are passed through unchanged.

Test Plan:
- Reset then rom_ready tied 1, no stall -> rom_addr sequence BFC00000, BFC00004, BFC00008 on consecutive cycles after the IDLE cycle; pc_out lags rom_addr by one cycle.
- Branch at BFC00008 in ID, branch_flag=1 with branch_addr=BFC00100 while rom_addr=BFC0000C, ready=1 -> rom_addr sequence BFC0000C, then BFC00100, then BFC00104 (delay slot fetched).
- Redirect while stalled: rom_ready=0 for 3 cycles, branch_flag=1 for 1 cycle with target 80001000 -> redirect_pending=1 until completion; the next request after the current pc completes is 80001000, and pending then clears.
- Flush with branch_flag=1 and rom_ready=1 in the same cycle, flush_pc=BFC00380 -> next rom_addr=BFC00380, pc_valid=0 that cycle, pending=0.
- stall_if=1 for 2 cycles after a completed fetch at 00400010 -> HOLD: rom_en=0 and pc_out=00400010 held valid; after release, rom_addr=00400014.
- FETCH_ALIGN_CHECK_EN defined, branch_addr=00400002 -> no rom_en for it; pc_out=00400002 with adel_flag=1; a subsequent flush clears adel_flag.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter with ID branch redirect, delay-slot handling and exception flush.
// Optional misaligned-fetch detection (adel_flag output) is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_pc_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_valid,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                  adel_flag,
`endif
  output logic                  redirect_pending
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_out;
  logic                  r_pc_valid;
  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_pend_addr;

  logic                  w_fetching;
  logic                  w_trap;
  logic                  w_complete;
  logic                  w_advance;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  assign w_fetching = (r_state == S_FETCH);

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_adel;

  // A misaligned pc never reaches memory; it "completes" on the next unstalled edge and parks in HOLD.
  assign w_trap     = (r_pc[1:0] != 2'b00);
  assign rom_en     = w_fetching && !w_trap;
  assign w_complete = w_fetching && (w_trap ? !stall_if : rom_ready);
  assign adel_flag  = r_adel;
`else
  assign w_trap     = 1'b0;
  assign rom_en     = w_fetching;
  assign w_complete = w_fetching && rom_ready;
`endif

  assign w_advance = (w_complete && !stall_if && !w_trap) ||
                     ((r_state == S_HOLD) && !stall_if);

  // A live branch in ID beats an older latched target, which beats sequential fetch.
  assign w_next_pc = branch_flag ? branch_addr :
                     r_pending   ? r_pend_addr :
                                   r_pc + ADDR_WIDTH'(4);

  assign rom_addr         = r_pc;
  assign pc_out           = r_pc_out;
  assign pc_valid         = r_pc_valid;
  assign redirect_pending = r_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_pc_out    <= '0;
      r_pc_valid  <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
    end else if (flush) begin
      r_state    <= S_FETCH;
      r_pc       <= flush_pc;
      r_pc_valid <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_complete) begin
            r_pc_out   <= r_pc;
            r_pc_valid <= 1'b1;
            if (stall_if || w_trap) r_state <= S_HOLD;
            else                    r_pc    <= w_next_pc;
          end else if (!stall_if) begin
            r_pc_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_if) begin
            r_pc       <= w_next_pc;
            r_pc_valid <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // The delay slot is already in flight when the branch shows up, so the target waits for the next advance.
      if (w_advance) begin
        r_pending <= 1'b0;
      end else if (branch_flag) begin
        r_pending   <= 1'b1;
        r_pend_addr <= branch_addr;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_adel <= 1'b0;
    else if (flush)             r_adel <= 1'b0;
    else if (w_complete && w_trap) r_adel <= 1'b1;
    else if (w_advance)         r_adel <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; covers FETCH_ALIGN_CHECK_EN when that macro is defined.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic        rom_ready;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        redirect_pending;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel_flag;
`endif

  int compared;
  int mismatched;

  fetch_pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall_if         (stall_if),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .branch_flag      (branch_flag),
    .branch_addr      (branch_addr),
    .rom_en           (rom_en),
    .rom_addr         (rom_addr),
    .rom_ready        (rom_ready),
    .pc_out           (pc_out),
    .pc_valid         (pc_valid),
`ifdef FETCH_ALIGN_CHECK_EN
    .adel_flag        (adel_flag),
`endif
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock, then settle just past the edge where outputs are stable and inputs may change.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; stall_if = 1'b0; flush = 1'b0; flush_pc = '0;
    branch_flag = 1'b0; branch_addr = '0; rom_ready = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_rom_en",   {31'd0, rom_en},           32'd0);
    checkOutput("reset_rom_addr", rom_addr,                  32'hBFC00000);
    checkOutput("reset_pc_out",   pc_out,                    32'h0);
    checkOutput("reset_valid",    {31'd0, pc_valid},         32'd0);
    checkOutput("reset_pending",  {31'd0, redirect_pending}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("reset_adel",     {31'd0, adel_flag},        32'd0);
`endif

    rst = 1'b0; rom_ready = 1'b1;
    applyStimulus();
    checkOutput("seq0_rom_en",   {31'd0, rom_en}, 32'd1);
    checkOutput("seq0_rom_addr", rom_addr,        32'hBFC00000);
    checkOutput("seq0_valid",    {31'd0, pc_valid}, 32'd0);
    applyStimulus();
    checkOutput("seq1_rom_addr", rom_addr,        32'hBFC00004);
    checkOutput("seq1_pc_out",   pc_out,          32'hBFC00000);
    checkOutput("seq1_valid",    {31'd0, pc_valid}, 32'd1);
    applyStimulus();
    checkOutput("seq2_rom_addr", rom_addr,        32'hBFC00008);
    checkOutput("seq2_pc_out",   pc_out,          32'hBFC00004);
    applyStimulus();
    checkOutput("seq3_rom_addr", rom_addr,        32'hBFC0000C);

    // Branch at BFC00008 resolves in ID while its delay slot BFC0000C is being fetched.
    branch_flag = 1'b1; branch_addr = 32'hBFC00100;
    applyStimulus();
    checkOutput("br_target_addr", rom_addr, 32'hBFC00100);
    checkOutput("br_slot_pc_out", pc_out,   32'hBFC0000C);
    checkOutput("br_pending",     {31'd0, redirect_pending}, 32'd0);
    branch_flag = 1'b0; branch_addr = '0;
    applyStimulus();
    checkOutput("br_after_addr",  rom_addr, 32'hBFC00104);
    checkOutput("br_after_pcout", pc_out,   32'hBFC00100);

    // Memory busy for three cycles while a one-cycle branch arrives.
    rom_ready = 1'b0; branch_flag = 1'b1; branch_addr = 32'h80001000;
    applyStimulus();
    checkOutput("wait_pending1", {31'd0, redirect_pending}, 32'd1);
    checkOutput("wait_addr1",    rom_addr,                  32'hBFC00104);
    checkOutput("wait_valid1",   {31'd0, pc_valid},         32'd0);
    branch_flag = 1'b0; branch_addr = '0;
    applyStimulus();
    checkOutput("wait_pending2", {31'd0, redirect_pending}, 32'd1);
    applyStimulus();
    checkOutput("wait_pending3", {31'd0, redirect_pending}, 32'd1);
    checkOutput("wait_addr3",    rom_addr,                  32'hBFC00104);
    rom_ready = 1'b1;
    applyStimulus();
    checkOutput("pend_target",   rom_addr,                  32'h80001000);
    checkOutput("pend_pc_out",   pc_out,                    32'hBFC00104);
    checkOutput("pend_cleared",  {31'd0, redirect_pending}, 32'd0);
    applyStimulus();
    checkOutput("pend_next",     rom_addr,                  32'h80001004);
    checkOutput("pend_next_out", pc_out,                    32'h80001000);

    // Flush wins over a simultaneous branch and completing fetch.
    flush = 1'b1; flush_pc = 32'hBFC00380; branch_flag = 1'b1; branch_addr = 32'h12345678;
    applyStimulus();
    checkOutput("flush_addr",    rom_addr,                  32'hBFC00380);
    checkOutput("flush_valid",   {31'd0, pc_valid},         32'd0);
    checkOutput("flush_pending", {31'd0, redirect_pending}, 32'd0);
    checkOutput("flush_pc_out",  pc_out,                    32'h80001000);
    flush = 1'b0; branch_flag = 1'b0; branch_addr = '0;
    applyStimulus();
    checkOutput("postflush_addr", rom_addr, 32'hBFC00384);
    checkOutput("postflush_out",  pc_out,   32'hBFC00380);

    // Downstream stall right after a fetch of 00400010 completes.
    flush = 1'b1; flush_pc = 32'h00400010;
    applyStimulus();
    flush = 1'b0; stall_if = 1'b1;
    applyStimulus();
    checkOutput("hold1_rom_en", {31'd0, rom_en},   32'd0);
    checkOutput("hold1_pc_out", pc_out,            32'h00400010);
    checkOutput("hold1_valid",  {31'd0, pc_valid}, 32'd1);
    applyStimulus();
    checkOutput("hold2_rom_en", {31'd0, rom_en},   32'd0);
    checkOutput("hold2_pc_out", pc_out,            32'h00400010);
    checkOutput("hold2_addr",   rom_addr,          32'h00400010);
    stall_if = 1'b0;
    applyStimulus();
    checkOutput("release_addr",   rom_addr,          32'h00400014);
    checkOutput("release_rom_en", {31'd0, rom_en},   32'd1);
    checkOutput("release_valid",  {31'd0, pc_valid}, 32'd0);
    applyStimulus();
    checkOutput("release_out",    pc_out,            32'h00400014);

    // Stalled with no response: pc_valid must be held, not cleared.
    rom_ready = 1'b0; stall_if = 1'b1;
    applyStimulus();
    checkOutput("stall_noready_valid", {31'd0, pc_valid}, 32'd1);
    checkOutput("stall_noready_addr",  rom_addr,          32'h00400018);
    rom_ready = 1'b1; stall_if = 1'b0;

    // Address wrap at the top of the space.
    flush = 1'b1; flush_pc = 32'hFFFFFFFC;
    applyStimulus();
    flush = 1'b0;
    checkOutput("wrap_top", rom_addr, 32'hFFFFFFFC);
    applyStimulus();
    checkOutput("wrap_zero",   rom_addr, 32'h00000000);
    checkOutput("wrap_pc_out", pc_out,   32'hFFFFFFFC);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned branch target is loaded but never requested from memory.
    branch_flag = 1'b1; branch_addr = 32'h00400002;
    applyStimulus();
    branch_flag = 1'b0; branch_addr = '0;
    checkOutput("adel_addr",   rom_addr,        32'h00400002);
    checkOutput("adel_rom_en", {31'd0, rom_en}, 32'd0);
    checkOutput("adel_pre",    {31'd0, adel_flag}, 32'd0);
    applyStimulus();
    checkOutput("adel_pc_out", pc_out,             32'h00400002);
    checkOutput("adel_valid",  {31'd0, pc_valid},  32'd1);
    checkOutput("adel_flag",   {31'd0, adel_flag}, 32'd1);
    checkOutput("adel_no_en",  {31'd0, rom_en},    32'd0);
    flush = 1'b1; flush_pc = 32'hBFC00380;
    applyStimulus();
    flush = 1'b0;
    checkOutput("adel_flush_clear", {31'd0, adel_flag}, 32'd0);
    checkOutput("adel_flush_addr",  rom_addr,           32'hBFC00380);
`endif

    // Asynchronous reset takes effect between clock edges.
    branch_flag = 1'b1; branch_addr = 32'h00001000; rom_ready = 1'b0;
    applyStimulus();
    branch_flag = 1'b0;
    checkOutput("pre_areset_pending", {31'd0, redirect_pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("areset_addr",    rom_addr,                  32'hBFC00000);
    checkOutput("areset_rom_en",  {31'd0, rom_en},           32'd0);
    checkOutput("areset_pending", {31'd0, redirect_pending}, 32'd0);
    checkOutput("areset_pc_out",  pc_out,                    32'h0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("after_areset_idle_exit", rom_addr, 32'hBFC00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
